// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared types and constants for the
// JPEG block sequencer slice.
package jpeg_pkg;

  localparam int PIXEL_COUNT = 64;
  localparam int COEF_COUNT  = 3 * PIXEL_COUNT;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DRAIN
  } seq_state_t;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

endpackage

// File: rtl/jpeg_coef_mux.sv
// jpeg_coef_mux: selects one zigzag coefficient
// out of the three held component planes.
module jpeg_coef_mux
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] y_zigzag,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] cb_zigzag,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] cr_zigzag,
  input  logic [1:0]                        comp,
  input  logic [5:0]                        index,
  output logic [DATA_WIDTH-1:0]             data
);

  // 192:1 select by {comp,index}
  always_comb begin
    data = '0;
    unique case (1'b1)
      (comp == COMP_Y):
        data = y_zigzag[index*DATA_WIDTH +: DATA_WIDTH];
      (comp == COMP_CB):
        data = cb_zigzag[index*DATA_WIDTH +: DATA_WIDTH];
      (comp == COMP_CR):
        data = cr_zigzag[index*DATA_WIDTH +: DATA_WIDTH];
      default:
        data = '0;
    endcase
  end

endmodule

// File: rtl/jpeg_block_sequencer.sv
// jpeg_block_sequencer: loads one 8x8 RGB block, waits out the
// pipeline latency, then drains Y/Cb/Cr zigzag coefficients.
module jpeg_block_sequencer
  import jpeg_pkg::*;
#(
  parameter int INPUT_WIDTH  = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int PIPE_LATENCY = 8
) (
  input  logic                                axi_aclk,
  input  logic                                axi_aresetn,
  input  logic                                start,
  input  logic                                abort,
  output logic                                busy,
  output logic                                done,
  output logic [15:0]                         block_count,
  input  logic [3*INPUT_WIDTH-1:0]            s_pix_data,
  input  logic                                s_pix_valid,
  output logic                                s_pix_ready,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0]  r_all,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0]  g_all,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0]  b_all,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0]   y_zigzag,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0]   cb_zigzag,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0]   cr_zigzag,
  output logic [DATA_WIDTH-1:0]               m_coef_data,
  output logic [1:0]                          m_coef_comp,
  output logic [5:0]                          m_coef_index,
  output logic                                m_coef_valid,
  input  logic                                m_coef_ready,
  output logic                                m_coef_last
);

  localparam int WCW = $clog2(PIPE_LATENCY + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(PIPE_LATENCY - 1);
  localparam logic [5:0] LAST_IDX = 6'(PIXEL_COUNT - 1);
  localparam int IW = INPUT_WIDTH;

  seq_state_t state_q, state_d;
  logic [5:0] pix_cnt_q, pix_cnt_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] comp_q, comp_d;
  logic [5:0] idx_q, idx_d;
  logic done_q, done_d;
  logic [15:0] block_count_q, block_count_d;
  logic pix_we;
  logic last_coef;
  logic [DATA_WIDTH-1:0] mux_data;
  logic [IW*PIXEL_COUNT-1:0] r_q, g_q, b_q;

  assign last_coef = (state_q == DRAIN) &&
                     (comp_q == COMP_CR) &&
                     (idx_q == LAST_IDX);

  // next-state, counters and handshake decode
  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    comp_d        = comp_q;
    idx_d         = idx_q;
    done_d        = 1'b0;
    block_count_d = block_count_q;
    pix_we        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = LOAD;
          pix_cnt_d = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (s_pix_valid) begin
          pix_we    = 1'b1;
          pix_cnt_d = pix_cnt_q + 6'd1;
          if (pix_cnt_q == LAST_IDX) begin
            state_d    = WAIT;
            wait_cnt_d = '0;
          end
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = DRAIN;
          comp_d  = COMP_Y;
          idx_d   = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          comp_d  = COMP_Y;
          idx_d   = '0;
        end else if (m_coef_ready) begin
          if (last_coef) begin
            state_d       = IDLE;
            done_d        = 1'b1;
            block_count_d = block_count_q + 16'd1;
            comp_d        = COMP_Y;
            idx_d         = '0;
          end else if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            comp_d = comp_q + 2'd1;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and counter registers
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q       <= IDLE;
      pix_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      comp_q        <= COMP_Y;
      idx_q         <= '0;
      done_q        <= 1'b0;
      block_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      comp_q        <= comp_d;
      idx_q         <= idx_d;
      done_q        <= done_d;
      block_count_q <= block_count_d;
    end
  end

  // pipeline input registers, one pixel per load handshake
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (pix_we) begin
      r_q[pix_cnt_q*IW +: IW] <= s_pix_data[2*IW +: IW];
      g_q[pix_cnt_q*IW +: IW] <= s_pix_data[IW +: IW];
      b_q[pix_cnt_q*IW +: IW] <= s_pix_data[0 +: IW];
    end
  end

  jpeg_coef_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux (
    .y_zigzag  (y_zigzag),
    .cb_zigzag (cb_zigzag),
    .cr_zigzag (cr_zigzag),
    .comp      (comp_q),
    .index     (idx_q),
    .data      (mux_data)
  );

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign block_count  = block_count_q;
  assign s_pix_ready  = (state_q == LOAD);
  assign r_all        = r_q;
  assign g_all        = g_q;
  assign b_all        = b_q;
  assign m_coef_valid = (state_q == DRAIN);
  assign m_coef_data  = m_coef_valid ? mux_data : '0;
  assign m_coef_comp  = comp_q;
  assign m_coef_index = idx_q;
  assign m_coef_last  = last_coef;

endmodule
